ex_mem_stage: RTL and testbench

Execute/memory stage of the 8-bit pipelined core. It sits directly downstream of the decode-to-execute pipeline register and consumes that register's outputs: immediate, operands A/B, register fields m1/m2 and the ALUSrc/ALUFn/MemWrite/MemRead/MemtoReg controls. It computes the ALU result, performs the data-memory access, and registers the write-back bundle for the final stage.

---
 rtl/ex_pkg.sv | 23 ++
 rtl/ex_alu.sv | 27 ++
 rtl/ex_mem_stage.sv | 100 ++++++++++
 tb/tb_ex_mem_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared constants and types for the execute/memory stage.
package ex_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_W  = 3;

  // ALU function select encoding.
  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_fn_e;

  // Registered write-back bundle handed to the final stage.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  dst;
    logic [REG_W-1:0]  src;
    logic              regwrite;
    logic              zero;
    logic              mem_err;
  } wb_bundle_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU: operand select, add/subtract with modulo wrap, zero detect.
module ex_alu
  import ex_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              alusrc_i,
  input  logic              alufn_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  logic [DATA_W-1:0] operand;

  // Select the second operand, then add or subtract; carry is discarded.
  always_comb begin
    operand = alusrc_i ? imm_i : b_i;
    if (alu_fn_e'(alufn_i) == ALU_SUB) begin
      result_o = a_i - operand;
    end else begin
      result_o = a_i + operand;
    end
    zero_o = (result_o == '0);
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute/memory stage: ALU, data memory with store-to-load bypass and range
// check, and the registered write-back bundle.
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk3,
  input  logic              rst,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] m1_in,
  input  logic [DATA_W-1:0] m2_in,
  input  logic              alusrc_in,
  input  logic              alufn_in,
  input  logic              memwrite_in,
  input  logic              memread_in,
  input  logic              memtoreg_in,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_dst,
  output logic [REG_W-1:0]  wb_src,
  output logic              wb_regwrite,
  output logic              wb_zero,
  output logic              mem_err
);

  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic              in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_idx;
  logic [DATA_W-1:0] mem_rd;
  logic [DATA_W-1:0] load_data;
  wb_bundle_t        wb_d, wb_q;

  logic [DATA_W-1:0] mem [DEPTH];

  ex_alu u_alu (
    .a_i      (a_in),
    .b_i      (b_in),
    .imm_i    (imm_in),
    .alusrc_i (alusrc_in),
    .alufn_i  (alufn_in),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );

  // Address decode, range check and load-data selection (bypass on same-address store).
  always_comb begin
    in_range = ({{(32-DATA_W){1'b0}}, alu_res} < DEPTH);
    mem_idx  = alu_res[ADDR_W-1:0];
    mem_we   = memwrite_in && in_range && !rst;
    mem_rd   = in_range ? mem[mem_idx] : '0;
    if (!memread_in || !in_range) begin
      load_data = '0;
    end else if (memwrite_in) begin
      load_data = b_in;
    end else begin
      load_data = mem_rd;
    end
  end

  // Assemble the next write-back bundle.
  always_comb begin
    wb_d          = '0;
    wb_d.data     = memtoreg_in ? load_data : alu_res;
    wb_d.dst      = m1_in[REG_W-1:0];
    wb_d.src      = m2_in[REG_W-1:0];
    wb_d.regwrite = !memwrite_in;
    wb_d.zero     = alu_zero;
    wb_d.mem_err  = (memread_in || memwrite_in) && !in_range;
  end

  // Data memory array; intentionally not reset so contents survive rst.
  always_ff @(posedge clk3) begin
    if (mem_we) begin
      mem[mem_idx] <= b_in;
    end
  end

  // Output register with asynchronous clear.
  always_ff @(posedge clk3 or posedge rst) begin
    if (rst) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign wb_data     = wb_q.data;
  assign wb_dst      = wb_q.dst;
  assign wb_src      = wb_q.src;
  assign wb_regwrite = wb_q.regwrite;
  assign wb_zero     = wb_q.zero;
  assign mem_err     = wb_q.mem_err;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;

  logic       clk3 = 1'b0;
  logic       rst;
  logic [7:0] imm_in, a_in, b_in, m1_in, m2_in;
  logic       alusrc_in, alufn_in, memwrite_in, memread_in, memtoreg_in;
  logic [7:0] wb_data;
  logic [2:0] wb_dst, wb_src;
  logic       wb_regwrite, wb_zero, mem_err;

  int checks = 0;
  int errors = 0;

  ex_mem_stage #(.DEPTH(16)) dut (
    .clk3        (clk3),
    .rst         (rst),
    .imm_in      (imm_in),
    .a_in        (a_in),
    .b_in        (b_in),
    .m1_in       (m1_in),
    .m2_in       (m2_in),
    .alusrc_in   (alusrc_in),
    .alufn_in    (alufn_in),
    .memwrite_in (memwrite_in),
    .memread_in  (memread_in),
    .memtoreg_in (memtoreg_in),
    .wb_data     (wb_data),
    .wb_dst      (wb_dst),
    .wb_src      (wb_src),
    .wb_regwrite (wb_regwrite),
    .wb_zero     (wb_zero),
    .mem_err     (mem_err)
  );

  always #5 clk3 = ~clk3;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] imm,
                       input logic [7:0] m1, input logic [7:0] m2, input logic src,
                       input logic fn, input logic mw, input logic mr, input logic mtr);
    a_in = a; b_in = b; imm_in = imm; m1_in = m1; m2_in = m2;
    alusrc_in = src; alufn_in = fn; memwrite_in = mw; memread_in = mr; memtoreg_in = mtr;
  endtask

  task automatic step();
    @(posedge clk3);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("rst_data", wb_data, 8'h00);
    chk("rst_dst", {5'b0, wb_dst}, 8'h00);
    chk("rst_src", {5'b0, wb_src}, 8'h00);
    chk("rst_regwrite", {7'b0, wb_regwrite}, 8'h00);
    chk("rst_zero", {7'b0, wb_zero}, 8'h00);
    chk("rst_err", {7'b0, mem_err}, 8'h00);
    step();
    rst = 1'b0;

    // add with immediate; only low 3 bits of register fields kept
    drive(8'h05, 8'h00, 8'h03, 8'hFA, 8'h0D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("add_data", wb_data, 8'h08);
    chk("add_dst", {5'b0, wb_dst}, 8'h02);
    chk("add_src", {5'b0, wb_src}, 8'h05);
    chk("add_zero", {7'b0, wb_zero}, 8'h00);
    chk("add_regwrite", {7'b0, wb_regwrite}, 8'h01);
    chk("add_err", {7'b0, mem_err}, 8'h00);

    // subtract to zero using operand B
    drive(8'h07, 8'h07, 8'h55, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("sub_data", wb_data, 8'h00);
    chk("sub_zero", {7'b0, wb_zero}, 8'h01);

    // wrap-around both directions
    drive(8'hFF, 8'h00, 8'h02, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("wrap_add", wb_data, 8'h01);
    drive(8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("wrap_sub", wb_data, 8'hFF);
    chk("wrap_sub_zero", {7'b0, wb_zero}, 8'h00);

    // store A5 at addr 4
    drive(8'h04, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("st_regwrite", {7'b0, wb_regwrite}, 8'h00);
    chk("st_data", wb_data, 8'h04);
    chk("st_err", {7'b0, mem_err}, 8'h00);

    // load addr 4
    drive(8'h04, 8'h00, 8'h00, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("ld_data", wb_data, 8'hA5);
    chk("ld_regwrite", {7'b0, wb_regwrite}, 8'h01);

    // same-cycle read+write at addr 5 bypasses store data, and the write lands
    drive(8'h05, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    chk("bypass_data", wb_data, 8'h3C);
    drive(8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("bypass_stored", wb_data, 8'h3C);

    // store 11 at addr 0, then out-of-range store at 0x20 must not alias onto entry 0
    drive(8'h00, 8'h11, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(8'h20, 8'h77, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("oor_st_err", {7'b0, mem_err}, 8'h01);
    drive(8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("oor_ld_data", wb_data, 8'h00);
    chk("oor_ld_err", {7'b0, mem_err}, 8'h01);
    drive(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("oor_no_alias", wb_data, 8'h11);
    chk("inrange_err", {7'b0, mem_err}, 8'h00);

    // memtoreg without memread gives zero, no error
    drive(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("mtr_noread_data", wb_data, 8'h00);
    chk("mtr_noread_err", {7'b0, mem_err}, 8'h00);

    // nonzero result, then async reset between edges
    drive(8'h05, 8'h00, 8'h03, 8'h07, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("pre_rst_data", wb_data, 8'h08);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_data", wb_data, 8'h00);
    chk("async_rst_dst", {5'b0, wb_dst}, 8'h00);
    chk("async_rst_src", {5'b0, wb_src}, 8'h00);
    chk("async_rst_regwrite", {7'b0, wb_regwrite}, 8'h00);

    // store to addr 4 during reset must be dropped
    drive(8'h04, 8'hEE, 8'h00, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    step();
    chk("rst_hold_data", wb_data, 8'h00);
    chk("rst_hold_regwrite", {7'b0, wb_regwrite}, 8'h00);
    rst = 1'b0;
    drive(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("mem_persist", wb_data, 8'hA5);
    chk("post_rst_err", {7'b0, mem_err}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
